// File: rtl/count_rollover_pkg.sv
// rtl/count_rollover_pkg.sv - shared state type and default sizing for count_rollover_ctrl
package count_rollover_pkg;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_TERMINAL      = 9;
    localparam int DEF_TENS_WIDTH    = 4;
    localparam int DEF_TENS_TERMINAL = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2,
        ERROR = 2'd3
    } state_e;

endpackage

// File: rtl/tens_digit_counter.sv
// rtl/tens_digit_counter.sv - cascaded tens digit with one-cycle carry on wrap
module tens_digit_counter
    import count_rollover_pkg::*;
#(
    parameter int TENS_WIDTH    = DEF_TENS_WIDTH,
    parameter int TENS_TERMINAL = DEF_TENS_TERMINAL
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  inc,
    output logic [TENS_WIDTH-1:0] tens,
    output logic                  carry_out
);

    localparam logic [TENS_WIDTH-1:0] TERM_V = TENS_WIDTH'(TENS_TERMINAL);

    logic [TENS_WIDTH-1:0] tens_d, tens_q;
    logic                  carry_d, carry_q;

    always_comb begin
        tens_d  = tens_q;
        carry_d = 1'b0;
        if (inc) begin
            if (tens_q == TERM_V) begin
                tens_d  = '0;
                carry_d = 1'b1;
            end else begin
                tens_d = tens_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            tens_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            tens_q  <= tens_d;
            carry_q <= carry_d;
        end
    end

    assign tens      = tens_q;
    assign carry_out = carry_q;

endmodule

// File: rtl/count_rollover_ctrl.sv
// rtl/count_rollover_ctrl.sv - supervises a negedge ripple counter: forced rollover, tens digit, sequence check
module count_rollover_ctrl
    import count_rollover_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int TERMINAL      = DEF_TERMINAL,
    parameter int TENS_WIDTH    = DEF_TENS_WIDTH,
    parameter int TENS_TERMINAL = DEF_TENS_TERMINAL
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      q_in,
    output logic                  clear_out,
    output logic [TENS_WIDTH-1:0] tens,
    output logic                  carry_out,
    output logic                  seq_error
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] prev_d, prev_q;
    logic [WIDTH-1:0] expect_q_in;
    logic             seq_error_d, seq_error_q;
    logic             clear_out_d, clear_out_q;
    logic             tens_inc;

    assign expect_q_in = prev_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        seq_error_d = seq_error_q;
        tens_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                prev_d = '0;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (q_in == TERM_V) begin
                    state_d  = CLEAR;
                    tens_inc = 1'b1;
                end else if (q_in != expect_q_in) begin
                    state_d     = ERROR;
                    seq_error_d = 1'b1;
                end else begin
                    prev_d = q_in;
                end
            end
            CLEAR: begin
                // The clear pulse zeroes the counter, so the next expected sample is 1.
                prev_d  = '0;
                state_d = enable ? RUN : IDLE;
            end
            ERROR: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered Moore output: decoded from the state being entered.
        clear_out_d = (state_d != RUN);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            seq_error_q <= 1'b0;
            clear_out_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            seq_error_q <= seq_error_d;
            clear_out_q <= clear_out_d;
        end
    end

    tens_digit_counter #(
        .TENS_WIDTH    (TENS_WIDTH),
        .TENS_TERMINAL (TENS_TERMINAL)
    ) u_tens (
        .clock     (clock),
        .clear_n   (clear_n),
        .inc       (tens_inc),
        .tens      (tens),
        .carry_out (carry_out)
    );

    assign clear_out = clear_out_q;
    assign seq_error = seq_error_q;

endmodule
